// File: rtl/sprite_pkg.sv
// ============================================================================
// Package     : sprite_pkg
// Description : Shared definitions for the sprite line server: default
//               geometry, the sprite bitmap table, the line-server FSM state
//               type and a bounds-safe table lookup helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_pkg;

   // Default geometry
   localparam int DEF_SPRITE_W    = 8;
   localparam int DEF_SPRITE_H    = 8;
   localparam int DEF_NUM_SPRITES = 3;
   localparam int DEF_NUM_FRAMES  = 2;
   localparam int TABLE_DEPTH     = DEF_NUM_SPRITES * DEF_NUM_FRAMES * DEF_SPRITE_H;

   // Bitmap words, grouped sprite-major, then frame, then row. MSB = leftmost pixel.
   localparam logic [DEF_SPRITE_W-1:0] SPRITE_TABLE [0:TABLE_DEPTH-1] = '{
      // sprite 0, frame 0
      8'h18, 8'h3C, 8'h7E, 8'hDB, 8'hFF, 8'h24, 8'h5A, 8'hA5,
      // sprite 0, frame 1
      8'h18, 8'h3C, 8'h7E, 8'hFF, 8'hA5, 8'h24, 8'h42, 8'h81,
      // sprite 1, frame 0
      8'h00, 8'h3C, 8'h42, 8'h99, 8'hBD, 8'h42, 8'h3C, 8'h00,
      // sprite 1, frame 1
      8'h24, 8'h7E, 8'hDB, 8'h56, 8'hFF, 8'h7E, 8'h24, 8'h66,
      // sprite 2, frame 0
      8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81,
      // sprite 2, frame 1
      8'h3C, 8'h66, 8'hC3, 8'h81, 8'h81, 8'hC3, 8'h66, 8'h3C
   };

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SHIFT = 2'd2
   } sprite_line_state_t;

   // Addresses beyond the table read as blank rather than wrapping.
   function automatic logic [DEF_SPRITE_W-1:0] sprite_table_word(input logic [31:0] addr);
      logic [DEF_SPRITE_W-1:0] word;
      word = '0;
      if (addr < 32'(TABLE_DEPTH)) begin
         word = SPRITE_TABLE[addr[5:0]];
      end
      return word;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_rom_sync.sv
// ============================================================================
// Module      : sprite_rom_sync
// Description : Registered single-port ROM holding the sprite table, one
//               cycle read latency. The output register only updates when
//               rd_en_i is high, so it doubles as the held line register.
// Ports       : Clk        - clock, rising edge
//               Reset_n    - asynchronous active-low reset (clears output)
//               rd_en_i    - load the addressed word into the output register
//               rd_addr_i  - word address
//               rd_data_o  - registered word
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_rom_sync
   import sprite_pkg::*;
#(
   parameter int WIDTH  = DEF_SPRITE_W,
   parameter int DEPTH  = TABLE_DEPTH,
   parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [WIDTH-1:0]  rd_data_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   always_comb begin
      data_d = '0;
      if (32'(rd_addr_i) < 32'(DEPTH)) begin
         data_d = WIDTH'(sprite_table_word(32'(rd_addr_i)));
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         data_q <= '0;
      end else if (rd_en_i) begin
         data_q <= data_d;
      end
   end

   assign rd_data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/sprite_line_server.sv
// ============================================================================
// Module      : sprite_line_server
// Description : Accepts a (sprite, frame, row) line request, reads the bitmap
//               word from a registered ROM, then streams it one pixel per
//               accepted beat. Out-of-range requests are accepted and produce
//               a blank line flagged by req_err.
// Build macro : SPRITE_MIRROR_EN - when defined, req_mirror is captured with
//               the request and reverses the pixel order of that line.
// Ports       : Clk, Reset_n                       - clock / async low reset
//               req_valid/req_ready                - request handshake
//               req_sprite/req_frame/req_row       - line selection
//               req_mirror                         - horizontal mirror
//               pix_valid/pix_ready                - pixel stream handshake
//               pix_data/pix_col/pix_last          - pixel beat payload
//               req_err                            - current line out of range
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_line_server
   import sprite_pkg::*;
#(
   parameter int SPRITE_W    = DEF_SPRITE_W,
   parameter int SPRITE_H    = DEF_SPRITE_H,
   parameter int NUM_SPRITES = DEF_NUM_SPRITES,
   parameter int NUM_FRAMES  = DEF_NUM_FRAMES,
   parameter int SID_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
   parameter int FR_W        = (NUM_FRAMES > 1)  ? $clog2(NUM_FRAMES)  : 1,
   parameter int ROW_W       = (SPRITE_H > 1)    ? $clog2(SPRITE_H)    : 1,
   parameter int COL_W       = (SPRITE_W > 1)    ? $clog2(SPRITE_W)    : 1
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [SID_W-1:0] req_sprite,
   input  logic [FR_W-1:0]  req_frame,
   input  logic [ROW_W-1:0] req_row,
   input  logic             req_mirror,
   output logic             pix_valid,
   input  logic             pix_ready,
   output logic             pix_data,
   output logic [COL_W-1:0] pix_col,
   output logic             pix_last,
   output logic             req_err
);

   localparam int DEPTH  = NUM_SPRITES * NUM_FRAMES * SPRITE_H;
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(SPRITE_W - 1);

   sprite_line_state_t state_q, state_d;
   logic [SID_W-1:0]   sprite_q, sprite_d;
   logic [FR_W-1:0]    frame_q, frame_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic               err_q, err_d;
   logic [COL_W-1:0]   col_q, col_d;

   logic               w_accept;
   logic               w_beat;
   logic               w_range_bad;
   logic               w_reverse;
   logic [ADDR_W-1:0]  w_rom_addr;
   logic [SPRITE_W-1:0] w_rom_word;
   logic [SPRITE_W-1:0] w_line;
   logic [COL_W-1:0]   w_bit_idx;

   assign w_accept = req_valid && (state_q == IDLE);
   assign w_beat   = (state_q == SHIFT) && pix_ready;

   assign w_range_bad = (32'(req_sprite) >= 32'(NUM_SPRITES)) ||
                        (32'(req_frame)  >= 32'(NUM_FRAMES))  ||
                        (32'(req_row)    >= 32'(SPRITE_H));

`ifdef SPRITE_MIRROR_EN
   logic mirror_q, mirror_d;

   always_comb begin
      mirror_d = mirror_q;
      if (w_accept) begin
         mirror_d = req_mirror;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         mirror_q <= 1'b0;
      end else begin
         mirror_q <= mirror_d;
      end
   end

   assign w_reverse = mirror_q;
`else
   logic w_unused_mirror;
   assign w_unused_mirror = req_mirror;
   assign w_reverse       = 1'b0;
`endif

   // Request capture and line sequencing
   always_comb begin
      state_d  = state_q;
      sprite_d = sprite_q;
      frame_d  = frame_q;
      row_d    = row_q;
      err_d    = err_q;
      col_d    = col_q;
      case (state_q)
         IDLE: begin
            if (w_accept) begin
               sprite_d = req_sprite;
               frame_d  = req_frame;
               row_d    = req_row;
               err_d    = w_range_bad;
               state_d  = FETCH;
            end
         end
         FETCH: begin
            col_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            if (w_beat) begin
               if (col_q == LAST_COL) begin
                  col_d   = '0;
                  state_d = IDLE;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= IDLE;
         sprite_q <= '0;
         frame_q  <= '0;
         row_q    <= '0;
         err_q    <= 1'b0;
         col_q    <= '0;
      end else begin
         state_q  <= state_d;
         sprite_q <= sprite_d;
         frame_q  <= frame_d;
         row_q    <= row_d;
         err_q    <= err_d;
         col_q    <= col_d;
      end
   end

   // Address arithmetic done at 32 bits, then narrowed to the ROM width.
   assign w_rom_addr = ADDR_W'((32'(sprite_q) * 32'(NUM_FRAMES) + 32'(frame_q))
                               * 32'(SPRITE_H) + 32'(row_q));

   // ROM output register is the line register; it loads only in FETCH.
   sprite_rom_sync #(
      .WIDTH  (SPRITE_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_rom (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .rd_en_i   (state_q == FETCH),
      .rd_addr_i (w_rom_addr),
      .rd_data_o (w_rom_word)
   );

   // Out-of-range lines are blanked regardless of what the ROM returned.
   assign w_line    = err_q ? '0 : w_rom_word;
   assign w_bit_idx = w_reverse ? col_q : (LAST_COL - col_q);

   assign req_ready = (state_q == IDLE);
   assign pix_valid = (state_q == SHIFT);
   assign pix_data  = pix_valid && w_line[w_bit_idx];
   assign pix_col   = col_q;
   assign pix_last  = pix_valid && (col_q == LAST_COL);
   assign req_err   = err_q;

endmodule

`default_nettype wire
